op_sequencer: RTL and testbench

// - Initiator side of the cpu op/start/done_out handshake; sits between host/testbench and cpu.
// - Holds a small program of `operation` words (types.svh), loaded through a write port.
// - On run, issues the words in order: drives op, pulses start, waits for done, advances.
// - Reports busy, pc, and a one-cycle finished pulse when the last word completes.

---
 rtl/op_sequencer.sv | 158 +++++++++++++++
 tb/tb_op_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_sequencer.sv
// Issues a stored program of operation words to a cpu over a start/done handshake.
// Define ISSUE_TIMEOUT_EN to bound each WAIT by TIMEOUT_CYCLES and add a sticky ERR state.
module op_sequencer #(
    parameter int PROG_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int OP_W           = 16     // width of one operation word
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [$clog2(PROG_DEPTH)-1:0] wr_addr,
    input  logic [OP_W-1:0]               wr_data,
    output logic                          wr_err,
    input  logic                          run,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic                          abort,
    output logic [OP_W-1:0]               op,
    output logic                          start,
    input  logic                          done_in,
    output logic                          busy,
    output logic [$clog2(PROG_DEPTH)-1:0] pc,
    output logic                          finished,
    output logic                          timeout_err
);
    localparam int AW = $clog2(PROG_DEPTH);
    localparam logic [AW:0] DEPTH_L = PROG_DEPTH[AW:0];

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FIN
`ifdef ISSUE_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    logic [OP_W-1:0] mem [PROG_DEPTH];

    state_t          state_reg, state_next;
    logic [AW-1:0]   pc_reg, pc_next;
    logic [AW:0]     len_reg, len_next, len_sat;
    logic [OP_W-1:0] op_reg;
    logic            wr_err_reg;
    logic            load_op, accept_run, wr_ok, last_word, timeout_hit;

    assign len_sat   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_word = ({1'b0, pc_reg} == (len_reg - 1'b1));
    assign wr_ok     = wr_en && (state_reg == IDLE);

`ifdef ISSUE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_reg;
    logic          timeout_err_reg;

    assign timeout_hit = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg == ISSUE)
                cnt_reg <= '0;
            else if (state_reg == WAIT)
                cnt_reg <= cnt_reg + 1'b1;
            if (accept_run)
                timeout_err_reg <= 1'b0;
            else if (state_reg == WAIT && state_next == ERR)
                timeout_err_reg <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    // The parameter stays referenced so builds without the timeout remain warning-free.
    assign timeout_hit = 1'b0;
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        len_next   = len_reg;
        load_op    = 1'b0;
        accept_run = 1'b0;
        case (state_reg)
            IDLE:  accept_run = run;
            ISSUE: state_next = abort ? IDLE : WAIT;
            WAIT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (done_in) begin
                    if (last_word) begin
                        state_next = FIN;
                    end else begin
                        pc_next    = pc_reg + 1'b1;
                        state_next = ISSUE;
                        load_op    = 1'b1;
                    end
                end
`ifdef ISSUE_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = ERR;
                end
`endif
            end
            FIN:   state_next = IDLE;
`ifdef ISSUE_TIMEOUT_EN
            ERR: begin
                if (abort)
                    state_next = IDLE;
                else
                    accept_run = run;
            end
`endif
            default: state_next = IDLE;
        endcase
        if (accept_run) begin
            len_next   = len_sat;
            pc_next    = '0;
            state_next = (len_sat == '0) ? FIN : ISSUE;
            load_op    = (len_sat != '0);
        end
    end

    // Program memory has no reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            pc_reg     <= '0;
            len_reg    <= '0;
            op_reg     <= '0;
            wr_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            len_reg    <= len_next;
            wr_err_reg <= wr_en && (state_reg != IDLE);
            // Forward a same-edge write so a run issued with it sees the new word.
            if (load_op)
                op_reg <= (wr_ok && wr_addr == pc_next) ? wr_data : mem[pc_next];
        end
    end

    assign op       = op_reg;
    assign start    = (state_reg == ISSUE);
    assign finished = (state_reg == FIN);
    assign busy     = (state_reg != IDLE);
    assign pc       = pc_reg;
    assign wr_err   = wr_err_reg;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: program issue, zero length, saturation, write rejection,
// abort, reset mid-program, same-cycle write+run and (with ISSUE_TIMEOUT_EN) the timeout.
module tb_op_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_err;
    logic        run;
    logic [4:0]  prog_len;
    logic        abort;
    logic [15:0] op;
    logic        start;
    logic        done_in;
    logic        busy;
    logic [3:0]  pc;
    logic        finished;
    logic        timeout_err;

    int vectors    = 0;
    int miscompares = 0;
    logic cpu_auto = 1'b0;
    int   cd = 0;

    op_sequencer #(.PROG_DEPTH(16), .TIMEOUT_CYCLES(8), .OP_W(16)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .run(run), .prog_len(prog_len), .abort(abort), .op(op),
        .start(start), .done_in(done_in), .busy(busy), .pc(pc), .finished(finished),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // cpu model: done_in for one cycle, two cycles after each start
    always @(negedge clk) begin
        if (cpu_auto) begin
            done_in = 1'b0;
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) done_in = 1'b1;
            end
            if (start) cd = 2;
        end else begin
            cd = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        $display("write mem[%0d] = %h", a, d);
    endtask

    // returns on the negedge after run has been sampled
    task automatic start_run(input logic [4:0] len);
        run = 1'b1; prog_len = len;
        @(negedge clk);
        run = 1'b0;
        $display("run prog_len=%0d", len);
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if ({start, busy, finished, wr_err, timeout_err} !== 5'b0 || pc !== 4'd0 || op !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got start=%b busy=%b fin=%b wr_err=%b to=%b pc=%0d op=%h expected all zero",
                     start, busy, finished, wr_err, timeout_err, pc, op);
        end
        $display("reset: start=%b busy=%b pc=%0d op=%h", start, busy, pc, op);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_program;
        logic [15:0] exp_op [3];
        int n = 0, fin = 0, b2b = 0;
        logic prev = 1'b0;
        exp_op[0] = 16'h1045; exp_op[1] = 16'h1235; exp_op[2] = 16'h2406;
        for (int i = 0; i < 3; i++) write_word(4'(i), exp_op[i]);
        cpu_auto = 1'b1;
        start_run(5'd3);
        for (int i = 0; i < 40; i++) begin
            if (start) begin
                if (n < 3) begin
                    vectors++;
                    if (op !== exp_op[n]) begin
                        miscompares++;
                        $display("FAIL prog_op%0d: got %h expected %h", n, op, exp_op[n]);
                    end
                    vectors++;
                    if (pc !== 4'(n)) begin
                        miscompares++;
                        $display("FAIL prog_pc%0d: got %0d expected %0d", n, pc, n);
                    end
                end
                $display("issue pc=%0d op=%h", pc, op);
                if (prev) b2b++;
                n++;
            end
            if (finished) fin++;
            prev = start;
            @(negedge clk);
        end
        vectors++;
        if (n != 3) begin miscompares++; $display("FAIL prog_starts: got %0d expected 3", n); end
        vectors++;
        if (fin != 1) begin miscompares++; $display("FAIL prog_finished: got %0d expected 1", fin); end
        vectors++;
        if (b2b != 0) begin miscompares++; $display("FAIL prog_back_to_back: got %0d expected 0", b2b); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL prog_busy_after: got %b expected 0", busy); end
        cpu_auto = 1'b0; done_in = 1'b0;
    endtask

    task automatic test_len_zero;
        start_run(5'd0);
        vectors++;
        if ({finished, busy, start} !== 3'b110) begin
            miscompares++;
            $display("FAIL len0_fin_cycle: got fin/busy/start=%b%b%b expected 110", finished, busy, start);
        end
        @(negedge clk);
        vectors++;
        if ({finished, busy, start} !== 3'b000) begin
            miscompares++;
            $display("FAIL len0_after: got fin/busy/start=%b%b%b expected 000", finished, busy, start);
        end
        $display("len0: done");
    endtask

    task automatic test_saturation;
        int n = 0;
        cpu_auto = 1'b1;
        start_run(5'd17);
        for (int i = 0; i < 80 && busy; i++) begin
            if (start) n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 16) begin miscompares++; $display("FAIL sat_starts: got %0d expected 16", n); end
        vectors++;
        if (pc !== 4'd15 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_end: got pc=%0d busy=%b expected pc=15 busy=0", pc, busy);
        end
        $display("saturation: %0d starts, last pc=%0d", n, pc);
        cpu_auto = 1'b0; done_in = 1'b0;
    endtask

    task automatic test_wr_busy;
        start_run(5'd3);
        @(negedge clk);                       // WAIT
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hDEAD;
        @(negedge clk);
        wr_en = 1'b0;
        vectors++;
        if (wr_err !== 1'b1) begin miscompares++; $display("FAIL wr_err_pulse: got %b expected 1", wr_err); end
        @(negedge clk);
        vectors++;
        if (wr_err !== 1'b0) begin miscompares++; $display("FAIL wr_err_clear: got %b expected 0", wr_err); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL wr_abort_idle: got busy=%b expected 0", busy); end
        start_run(5'd1);
        vectors++;
        if (start !== 1'b1 || op !== 16'h1045) begin
            miscompares++;
            $display("FAIL wr_mem_unchanged: got start=%b op=%h expected 1 1045", start, op);
        end
        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        vectors++;
        if (finished !== 1'b1) begin miscompares++; $display("FAIL wr_len1_fin: got %b expected 1", finished); end
        @(negedge clk);
        $display("wr_busy: op reread=%h", op);
    endtask

    task automatic test_abort_done;
        int s = 0, f = 0;
        start_run(5'd3);
        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        vectors++;
        if (start !== 1'b1 || pc !== 4'd1) begin
            miscompares++;
            $display("FAIL abort_issue1: got start=%b pc=%0d expected 1 1", start, pc);
        end
        @(negedge clk);
        done_in = 1'b1; abort = 1'b1;
        @(negedge clk);
        done_in = 1'b0; abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || pc !== 4'd1 || op !== 16'h1235 || start !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: got busy=%b pc=%0d op=%h start=%b expected 0 1 1235 0",
                     busy, pc, op, start);
        end
        for (int i = 0; i < 6; i++) begin
            if (start) s++;
            if (finished) f++;
            @(negedge clk);
        end
        vectors++;
        if (s != 0 || f != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: got starts=%0d finished=%0d expected 0 0", s, f);
        end
        $display("abort: pc=%0d busy=%b", pc, busy);
    endtask

    task automatic test_reset_mid;
        start_run(5'd3);
        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        @(negedge clk);                       // WAIT of op 1
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({start, busy, finished} !== 3'b000 || pc !== 4'd0 || op !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got start=%b busy=%b fin=%b pc=%0d op=%h expected zeros",
                     start, busy, finished, pc, op);
        end
        @(negedge clk);
        reset = 1'b0;
        cpu_auto = 1'b1;
        start_run(5'd1);
        vectors++;
        if (start !== 1'b1 || pc !== 4'd0 || op !== 16'h1045) begin
            miscompares++;
            $display("FAIL reset_restart: got start=%b pc=%0d op=%h expected 1 0 1045", start, pc, op);
        end
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_restart_done: got busy=%b expected 0", busy); end
        cpu_auto = 1'b0; done_in = 1'b0;
        $display("reset_mid: restarted from pc=0");
    endtask

    task automatic test_wr_and_run;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h3A5C;
        start_run(5'd1);
        wr_en = 1'b0;
        vectors++;
        if (start !== 1'b1 || op !== 16'h3A5C) begin
            miscompares++;
            $display("FAIL wr_run_forward: got start=%b op=%h expected 1 3a5c", start, op);
        end
        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        vectors++;
        if (finished !== 1'b1) begin miscompares++; $display("FAIL wr_run_fin: got %b expected 1", finished); end
        @(negedge clk);
        $display("wr_and_run: op=%h", op);
    endtask

`ifdef ISSUE_TIMEOUT_EN
    task automatic test_timeout;
        int first_err = -1;
        start_run(5'd1);
        for (int i = 0; i < 20; i++) begin
            if (timeout_err && first_err < 0) first_err = i;
            @(negedge clk);
        end
        vectors++;
        if (first_err != 9) begin miscompares++; $display("FAIL timeout_cycle: got %0d expected 9", first_err); end
        vectors++;
        if (timeout_err !== 1'b1 || start !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_sticky: got to=%b start=%b expected 1 0", timeout_err, start);
        end
        start_run(5'd1);
        vectors++;
        if (timeout_err !== 1'b0 || start !== 1'b1 || pc !== 4'd0 || op !== 16'h3A5C) begin
            miscompares++;
            $display("FAIL timeout_rerun: got to=%b start=%b pc=%0d op=%h expected 0 1 0 3a5c",
                     timeout_err, start, pc, op);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        $display("timeout: err seen at cycle %0d", first_err);
    endtask
`endif

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        run = 1'b0; prog_len = '0; abort = 1'b0; done_in = 1'b0;
        test_reset();
        test_program();
        test_len_zero();
        test_saturation();
        test_wr_busy();
        test_abort_done();
        test_reset_mid();
        test_wr_and_run();
`ifdef ISSUE_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
